// File: rtl/apb_master_if.sv
// APB request/response bus shared between one master and four slaves.
// The master drives the common request lines and one select per slave;
// each slave returns its own read data and ready.
interface apb_master_if;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic        PSEL0;
  logic        PSEL1;
  logic        PSEL2;
  logic        PSEL3;
  logic [31:0] PRDATA0;
  logic [31:0] PRDATA1;
  logic [31:0] PRDATA2;
  logic [31:0] PRDATA3;
  logic        PREADY0;
  logic        PREADY1;
  logic        PREADY2;
  logic        PREADY3;

  modport master (
    output PADDR, PWRITE, PENABLE, PWDATA,
    output PSEL0, PSEL1, PSEL2, PSEL3,
    input  PRDATA0, PRDATA1, PRDATA2, PRDATA3,
    input  PREADY0, PREADY1, PREADY2, PREADY3
  );

  modport slave (
    input  PADDR, PWRITE, PENABLE, PWDATA,
    input  PSEL0, PSEL1, PSEL2, PSEL3,
    output PRDATA0, PRDATA1, PRDATA2, PRDATA3,
    output PREADY0, PREADY1, PREADY2, PREADY3
  );
endinterface

// File: rtl/apb_master.sv
// APB master bridging a simple core request strobe onto a four-slave APB
// window. One transfer in flight at a time: IDLE -> SETUP -> ACCESS -> IDLE.
// Completion is reported with a one-cycle ready pulse carrying rdata/err.
// Unmapped addresses and ACCESS-phase timeouts complete with err=1.
module apb_master #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic         PCLK,
  input  logic         PRESET,
  input  logic         transfer,
  input  logic         write,
  input  logic [31:0]  addr,
  input  logic [31:0]  wdata,
  output logic [31:0]  rdata,
  output logic         ready,
  output logic         err,
  apb_master_if.master bus
);

  // Counter only needs to reach TIMEOUT-1; a disabled timeout keeps a 1-bit stub.
  localparam int unsigned    CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit             TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;

  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic             req_write;
  logic [1:0]       sel;
  logic [CNT_W-1:0] cnt;

  logic             hit;
  logic [1:0]       req_slave;
  logic             sel_ready;
  logic [31:0]      sel_rdata;
  logic             accept;
  logic             miss;
  logic             done_ok;
  logic             done_to;
  logic             active;

  // Address decode of the incoming core request into one of four 4 KB slots.
  always_comb begin
    hit       = (addr[31:14] == BASE_ADDR[31:14]);
    req_slave = addr[13:12];
  end

  // Only the selected slave's ready/read data are observed.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    case (sel)
      2'd0: begin sel_ready = bus.PREADY0; sel_rdata = bus.PRDATA0; end
      2'd1: begin sel_ready = bus.PREADY1; sel_rdata = bus.PRDATA1; end
      2'd2: begin sel_ready = bus.PREADY2; sel_rdata = bus.PRDATA2; end
      2'd3: begin sel_ready = bus.PREADY3; sel_rdata = bus.PRDATA3; end
      default: begin sel_ready = 1'b0; sel_rdata = '0; end
    endcase
  end

  // FSM state register; reset aborts any transfer in flight.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and completion decode. Requests are only taken in IDLE,
  // which includes the cycle that carries the previous ready pulse.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    miss       = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    case (state)
      IDLE: begin
        if (transfer) begin
          accept = 1'b1;
          if (hit) begin
            next_state = SETUP;
          end else begin
            miss = 1'b1;
          end
        end
      end
      SETUP: begin
        next_state = ACCESS;
      end
      ACCESS: begin
        if (sel_ready) begin
          done_ok    = 1'b1;
          next_state = IDLE;
        end else if (TO_EN && (cnt == TO_LAST)) begin
          done_to    = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request capture: address/data/direction and slave index held until completion.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      req_addr  <= '0;
      req_wdata <= '0;
      req_write <= 1'b0;
      sel       <= 2'd0;
    end else if (accept) begin
      req_addr  <= addr;
      req_wdata <= wdata;
      req_write <= write;
      sel       <= req_slave;
    end
  end

  // ACCESS-phase cycle counter; restarts from zero each time ACCESS is entered.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      cnt <= '0;
    end else if (state == ACCESS) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Completion response: one-cycle ready pulse; rdata/err hold between pulses.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= 1'b0;
      if (miss) begin
        ready <= 1'b1;
        err   <= 1'b1;
        rdata <= '0;
      end else if (done_ok) begin
        ready <= 1'b1;
        err   <= 1'b0;
        rdata <= req_write ? 32'h0 : sel_rdata;
      end else if (done_to) begin
        ready <= 1'b1;
        err   <= 1'b1;
        rdata <= '0;
      end
    end
  end

  // Bus drive: selects decoded from the FSM so at most one is ever high.
  assign active      = (state != IDLE);
  assign bus.PSEL0   = active && (sel == 2'd0);
  assign bus.PSEL1   = active && (sel == 2'd1);
  assign bus.PSEL2   = active && (sel == 2'd2);
  assign bus.PSEL3   = active && (sel == 2'd3);
  assign bus.PENABLE = (state == ACCESS);
  assign bus.PADDR   = req_addr;
  assign bus.PWDATA  = req_wdata;
  assign bus.PWRITE  = req_write;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: four behavioural slaves with programmable wait
// states, a scoreboard queue of expected completions, and one task per scenario.
module tb_apb_master;

  localparam int HANG = 255;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        PCLK;
  logic        PRESET;
  logic        transfer;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb[$];

  int          waits[4];
  logic [31:0] slv_rd[4];
  int          acc_cnt = 0;
  logic [3:0]  psel;

  apb_master_if bus ();

  apb_master #(
    .BASE_ADDR(32'h1000_0000),
    .TIMEOUT  (16)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .transfer(transfer),
    .write   (write),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ready   (ready),
    .err     (err),
    .bus     (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  assign psel = {bus.PSEL3, bus.PSEL2, bus.PSEL1, bus.PSEL0};

  // Slave models: selected slave answers after waits[i] ACCESS cycles;
  // unselected slaves present ready=1 and junk data, which must be ignored.
  always @(posedge PCLK) acc_cnt <= bus.PENABLE ? acc_cnt + 1 : 0;

  assign bus.PREADY0 = (bus.PSEL0 && bus.PENABLE) ? (waits[0] != HANG && acc_cnt >= waits[0]) : 1'b1;
  assign bus.PREADY1 = (bus.PSEL1 && bus.PENABLE) ? (waits[1] != HANG && acc_cnt >= waits[1]) : 1'b1;
  assign bus.PREADY2 = (bus.PSEL2 && bus.PENABLE) ? (waits[2] != HANG && acc_cnt >= waits[2]) : 1'b1;
  assign bus.PREADY3 = (bus.PSEL3 && bus.PENABLE) ? (waits[3] != HANG && acc_cnt >= waits[3]) : 1'b1;
  assign bus.PRDATA0 = bus.PSEL0 ? slv_rd[0] : 32'hBAD0_0000;
  assign bus.PRDATA1 = bus.PSEL1 ? slv_rd[1] : 32'hBAD0_0001;
  assign bus.PRDATA2 = bus.PSEL2 ? slv_rd[2] : 32'hBAD0_0002;
  assign bus.PRDATA3 = bus.PSEL3 ? slv_rd[3] : 32'hBAD0_0003;

  // Scoreboard monitor: every ready pulse pops the oldest expected completion.
  always @(negedge PCLK) begin
    exp_t e;
    if (ready === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected_ready: got ready=1 rdata=%h err=%b, required no pulse", rdata, err);
      end else begin
        e = sb.pop_front();
        if (rdata !== e.rdata || err !== e.err) begin
          n_bad++;
          $display("FAIL sb_result: got rdata=%h err=%b, required rdata=%h err=%b", rdata, err, e.rdata, e.err);
        end
      end
    end
    if (psel !== 4'b0000) begin
      n_cmp++;
      if (!$onehot(psel)) begin
        n_bad++;
        $display("FAIL psel_onehot: got psel=%b, required at most one bit set", psel);
      end
    end
  end

  task automatic push_exp(input logic [31:0] rd, input logic e);
    exp_t x;
    x.rdata = rd;
    x.err   = e;
    sb.push_back(x);
  endtask

  // Present one request for exactly one sampling edge, then scramble inputs.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge PCLK);
    transfer = 1'b1;
    write    = w;
    addr     = a;
    wdata    = d;
    @(posedge PCLK);
    #1;
    transfer = 1'b0;
    write    = ~w;
    addr     = $urandom;
    wdata    = $urandom;
  endtask

  // Count negedges after the accepting edge until ready, bounded by budget.
  task automatic wait_ready(input int budget, output int lat);
    lat = 0;
    do begin
      @(negedge PCLK);
      lat++;
    end while (ready !== 1'b1 && lat < budget);
  endtask

  task automatic test_reset;
    PRESET = 1'b0;
    repeat (3) @(negedge PCLK);
    n_cmp++;
    if (psel !== 4'b0000 || bus.PENABLE !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_sel: got psel=%b penable=%b, required 0000/0", psel, bus.PENABLE);
    end
    n_cmp++;
    if (ready !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_resp: got ready=%b err=%b rdata=%h, required 0/0/0", ready, err, rdata);
    end
    n_cmp++;
    if (bus.PADDR !== 32'h0 || bus.PWDATA !== 32'h0 || bus.PWRITE !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_req: got paddr=%h pwdata=%h pwrite=%b, required 0/0/0", bus.PADDR, bus.PWDATA, bus.PWRITE);
    end
    PRESET = 1'b1;
    repeat (2) @(negedge PCLK);
    n_cmp++;
    if (psel !== 4'b0000 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got psel=%b ready=%b, required 0000/0", psel, ready);
    end
  endtask

  task automatic test_write;
    waits[0] = 0;
    push_exp(32'h0, 1'b0);
    issue(1'b1, 32'h1000_0010, 32'hDEAD_BEEF);
    @(negedge PCLK);
    n_cmp++;
    if (psel !== 4'b0001 || bus.PENABLE !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_setup: got psel=%b penable=%b, required 0001/0", psel, bus.PENABLE);
    end
    n_cmp++;
    if (bus.PADDR !== 32'h1000_0010 || bus.PWRITE !== 1'b1 || bus.PWDATA !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL wr_setup_bus: got paddr=%h pwrite=%b pwdata=%h, required 10000010/1/deadbeef",
               bus.PADDR, bus.PWRITE, bus.PWDATA);
    end
    @(negedge PCLK);
    n_cmp++;
    if (psel !== 4'b0001 || bus.PENABLE !== 1'b1 || bus.PWDATA !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL wr_access: got psel=%b penable=%b pwdata=%h, required 0001/1/deadbeef",
               psel, bus.PENABLE, bus.PWDATA);
    end
    @(negedge PCLK);
    n_cmp++;
    if (ready !== 1'b1 || err !== 1'b0 || psel !== 4'b0000 || bus.PENABLE !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_done: got ready=%b err=%b psel=%b penable=%b, required 1/0/0000/0",
               ready, err, psel, bus.PENABLE);
    end
    @(negedge PCLK);
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_pulse: got ready=%b one cycle later, required 0", ready);
    end
  endtask

  task automatic test_read_wait;
    int lat;
    waits[2]  = 1;
    slv_rd[2] = 32'h1234_5678;
    push_exp(32'h1234_5678, 1'b0);
    issue(1'b0, 32'h1000_2004, 32'h0);
    wait_ready(10, lat);
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL rd_latency: got %0d cycles, required 4", lat);
    end
    n_cmp++;
    if (rdata !== 32'h1234_5678 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_data: got rdata=%h err=%b, required 12345678/0", rdata, err);
    end
    repeat (2) @(negedge PCLK);
    n_cmp++;
    if (ready !== 1'b0 || rdata !== 32'h1234_5678 || err !== 1'b0 || psel !== 4'b0000) begin
      n_bad++;
      $display("FAIL rd_hold: got ready=%b rdata=%h err=%b psel=%b, required 0/12345678/0/0000",
               ready, rdata, err, psel);
    end
  endtask

  task automatic test_unmapped;
    push_exp(32'h0, 1'b1);
    issue(1'b0, 32'h2000_0000, 32'h0);
    @(negedge PCLK);
    n_cmp++;
    if (ready !== 1'b1 || err !== 1'b1 || rdata !== 32'h0 || psel !== 4'b0000) begin
      n_bad++;
      $display("FAIL unmapped_resp: got ready=%b err=%b rdata=%h psel=%b, required 1/1/0/0000",
               ready, err, rdata, psel);
    end
    @(negedge PCLK);
    n_cmp++;
    if (ready !== 1'b0 || psel !== 4'b0000 || bus.PENABLE !== 1'b0) begin
      n_bad++;
      $display("FAIL unmapped_after: got ready=%b psel=%b penable=%b, required 0/0000/0",
               ready, psel, bus.PENABLE);
    end
  endtask

  task automatic test_timeout;
    int lat;
    int acc;
    waits[1] = HANG;
    push_exp(32'h0, 1'b1);
    issue(1'b0, 32'h1000_1000, 32'h0);
    lat = 0;
    acc = 0;
    do begin
      @(negedge PCLK);
      lat++;
      if (bus.PENABLE === 1'b1 && psel === 4'b0010) acc++;
    end while (ready !== 1'b1 && lat < 40);
    n_cmp++;
    if (acc !== 16) begin
      n_bad++;
      $display("FAIL to_access_cycles: got %0d, required 16", acc);
    end
    n_cmp++;
    if (lat !== 18) begin
      n_bad++;
      $display("FAIL to_latency: got %0d cycles, required 18", lat);
    end
    n_cmp++;
    if (ready !== 1'b1 || err !== 1'b1 || psel !== 4'b0000 || bus.PENABLE !== 1'b0) begin
      n_bad++;
      $display("FAIL to_done: got ready=%b err=%b psel=%b penable=%b, required 1/1/0000/0",
               ready, err, psel, bus.PENABLE);
    end
  endtask

  task automatic test_back_to_back;
    logic        w[4];
    logic [31:0] a[4];
    logic [31:0] d[4];
    int          gap;
    waits[0]  = 0;
    waits[3]  = 0;
    slv_rd[3] = 32'hCAFE_0003;
    w[0] = 1'b1; a[0] = 32'h1000_0020; d[0] = 32'hA1A1_0001;
    w[1] = 1'b0; a[1] = 32'h1000_3008; d[1] = 32'h0;
    w[2] = 1'b1; a[2] = 32'h1000_0024; d[2] = 32'hA1A1_0002;
    w[3] = 1'b0; a[3] = 32'h1000_300C; d[3] = 32'h0;
    @(negedge PCLK);
    transfer = 1'b1; write = w[0]; addr = a[0]; wdata = d[0];
    push_exp(32'h0, 1'b0);
    @(posedge PCLK);
    for (int k = 1; k <= 4; k++) begin
      @(negedge PCLK);
      if (k < 4) begin
        write = w[k]; addr = a[k]; wdata = d[k];
        push_exp(w[k] ? 32'h0 : slv_rd[3], 1'b0);
      end else begin
        transfer = 1'b0;
      end
      gap = 1;
      while (ready !== 1'b1 && gap < 20) begin
        @(negedge PCLK);
        gap++;
      end
      n_cmp++;
      if (gap !== 3) begin
        n_bad++;
        $display("FAIL b2b_gap_%0d: got %0d cycles, required 3", k - 1, gap);
      end
      if (k < 4) @(posedge PCLK);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int seen;
    waits[1] = HANG;
    issue(1'b1, 32'h1000_1040, 32'h5555_AAAA);
    repeat (3) @(negedge PCLK);
    #2 PRESET = 1'b0;
    #1;
    n_cmp++;
    if (psel !== 4'b0000 || bus.PENABLE !== 1'b0 || ready !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_async_ctrl: got psel=%b penable=%b ready=%b err=%b, required all 0",
               psel, bus.PENABLE, ready, err);
    end
    n_cmp++;
    if (bus.PADDR !== 32'h0 || bus.PWDATA !== 32'h0 || bus.PWRITE !== 1'b0 || rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_async_data: got paddr=%h pwdata=%h pwrite=%b rdata=%h, required all 0",
               bus.PADDR, bus.PWDATA, bus.PWRITE, rdata);
    end
    seen = 0;
    repeat (3) begin
      @(negedge PCLK);
      if (ready !== 1'b0) seen++;
    end
    PRESET = 1'b1;
    repeat (2) begin
      @(negedge PCLK);
      if (ready !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL rst_no_ready: got %0d ready cycles, required 0", seen);
    end
    waits[1] = 0;
    push_exp(32'h0, 1'b0);
    issue(1'b1, 32'h1000_1044, 32'h0BAD_F00D);
    wait_ready(10, lat);
    n_cmp++;
    if (lat !== 3 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_after: got latency=%0d err=%b, required 3/0", lat, err);
    end
  endtask

  initial begin
    PRESET   = 1'b0;
    transfer = 1'b0;
    write    = 1'b0;
    addr     = 32'h0;
    wdata    = 32'h0;
    for (int i = 0; i < 4; i++) begin
      waits[i]  = 0;
      slv_rd[i] = 32'h0;
    end
    test_reset();
    test_write();
    test_read_wait();
    test_unmapped();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge PCLK);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d outstanding completions, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
